exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/exe_pkg.sv | 55 +++++
 rtl/seq_multiplier.sv | 64 ++++++
 rtl/exe_stage.sv | 100 ++++++++++
 tb/tb_exe_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: operation codes, multiplier FSM
// encoding, the held context of an in-flight multiply and the single-cycle ALU.
package exe_pkg;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRL = 4'b1001;
  localparam logic [3:0] EXE_SRA = 4'b1010;
  localparam logic [3:0] EXE_MUL = 4'b1100;

  localparam int MUL_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } exe_state_e;

  // Everything a multiply must deliver alongside its product once it finishes.
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] st_val;
    logic [31:0] br_addr;
    logic        br_taken;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
  } mul_ctx_t;

  function automatic logic [31:0] alu_calc(input logic [3:0] cmd,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (cmd)
      EXE_ADD: r = a + b;
      EXE_SUB: r = a - b;
      EXE_AND: r = a & b;
      EXE_OR:  r = a | b;
      EXE_NOR: r = ~(a | b);
      EXE_XOR: r = a ^ b;
      EXE_SLL: r = a << b[4:0];
      EXE_SRL: r = a >> b[4:0];
      EXE_SRA: r = $unsigned($signed(a) >>> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative 32x32 multiplier keeping the low 32 product bits: one shift-add
// step per cycle, then a single DONE cycle in which the product is presented.
module seq_multiplier
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output exe_state_e  state
);

  exe_state_e  state_next;
  logic [4:0]  cnt;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] acc;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_BUSY;
      ST_BUSY: if (cnt == 5'(MUL_CYCLES - 1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (state == ST_IDLE && start) begin
        ma  <= a;
        mb  <= b;
        acc <= '0;
        cnt <= '0;
      end else if (state == ST_BUSY) begin
        // Bits shifted past position 31 are discarded, giving the low word.
        if (mb[cnt]) acc <= acc + (ma << cnt);
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign busy    = (state == ST_BUSY);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU and branch target, plus a stalling
// sequential multiply whose result is written with its held controls.
module exe_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] PC_in,
  input  logic [4:0]  Dest_in,
  input  logic [31:0] Reg2_in,
  input  logic [31:0] Val1_in,
  input  logic [31:0] Val2_in,
  input  logic [3:0]  EXE_CMD_in,
  input  logic        Br_taken_in,
  input  logic        MEM_R_EN_in,
  input  logic        MEM_W_EN_in,
  input  logic        WB_EN_in,
  output logic [31:0] ALU_result,
  output logic [31:0] ST_val,
  output logic [4:0]  Dest,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  output logic        WB_EN,
  output logic [31:0] Br_addr,
  output logic        Br_taken,
  output logic        stall,
  output exe_state_e  fsm_state
);

  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_product;
  logic [31:0] br_calc;
  mul_ctx_t    ctx;

  assign br_calc   = PC_in + {Val2_in[29:0], 2'b00};
  assign mul_start = !flush && (fsm_state == ST_IDLE) && (EXE_CMD_in == EXE_MUL);
  // Reset and flush both force stall low the moment they are asserted.
  assign stall     = !rst && !flush && (mul_start || mul_busy);

  seq_multiplier u_mul (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush),
    .start   (mul_start),
    .a       (Val1_in),
    .b       (Val2_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product),
    .state   (fsm_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_result <= '0;
      ST_val     <= '0;
      Dest       <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
      WB_EN      <= 1'b0;
      Br_addr    <= '0;
      Br_taken   <= 1'b0;
      ctx        <= '0;
    end else begin
      if (mul_start)
        ctx <= '{dest: Dest_in, st_val: Reg2_in, br_addr: br_calc,
                 br_taken: Br_taken_in, mem_r_en: MEM_R_EN_in,
                 mem_w_en: MEM_W_EN_in, wb_en: WB_EN_in};
      if (flush || stall) begin
        // Bubble: kill side effects, leave data outputs as they were.
        MEM_R_EN <= 1'b0;
        MEM_W_EN <= 1'b0;
        WB_EN    <= 1'b0;
        Br_taken <= 1'b0;
      end else if (mul_done) begin
        ALU_result <= mul_product;
        ST_val     <= ctx.st_val;
        Dest       <= ctx.dest;
        MEM_R_EN   <= ctx.mem_r_en;
        MEM_W_EN   <= ctx.mem_w_en;
        WB_EN      <= ctx.wb_en;
        Br_addr    <= ctx.br_addr;
        Br_taken   <= ctx.br_taken;
      end else begin
        ALU_result <= alu_calc(EXE_CMD_in, Val1_in, Val2_in);
        ST_val     <= Reg2_in;
        Dest       <= Dest_in;
        MEM_R_EN   <= MEM_R_EN_in;
        MEM_W_EN   <= MEM_W_EN_in;
        WB_EN      <= WB_EN_in;
        Br_addr    <= br_calc;
        Br_taken   <= Br_taken_in;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: fixed vectors, multiply flush/reset sequences and
// random operations checked against an arithmetic reference model.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] PC_in;
  logic [4:0]  Dest_in;
  logic [31:0] Reg2_in;
  logic [31:0] Val1_in;
  logic [31:0] Val2_in;
  logic [3:0]  EXE_CMD_in;
  logic        Br_taken_in;
  logic        MEM_R_EN_in;
  logic        MEM_W_EN_in;
  logic        WB_EN_in;
  logic [31:0] ALU_result;
  logic [31:0] ST_val;
  logic [4:0]  Dest;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        WB_EN;
  logic [31:0] Br_addr;
  logic        Br_taken;
  logic        stall;
  exe_state_e  fsm_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  logic [4:0]  drv_dest;
  logic [31:0] drv_reg2;
  logic        drv_mr;
  logic        drv_mw;

  exe_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .PC_in(PC_in), .Dest_in(Dest_in),
    .Reg2_in(Reg2_in), .Val1_in(Val1_in), .Val2_in(Val2_in),
    .EXE_CMD_in(EXE_CMD_in), .Br_taken_in(Br_taken_in),
    .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in), .WB_EN_in(WB_EN_in),
    .ALU_result(ALU_result), .ST_val(ST_val), .Dest(Dest),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN),
    .Br_addr(Br_addr), .Br_taken(Br_taken), .stall(stall),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_alu(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] w;
    int sh;
    sh = int'(b % 32);
    case (c)
      4'h0: return a + b;
      4'h2: return a - b;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return ~(a | b);
      4'h7: return a ^ b;
      4'h8: return a << sh;
      4'h9: return a >> sh;
      4'hA: begin w = {{32{a[31]}}, a} >> sh; return w[31:0]; end
      4'hC: begin w = 64'(a) * 64'(b); return w[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_br(input logic [31:0] pc, input logic [31:0] off);
    return pc + off * 4;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one instruction, waits out any stall (bounded), then takes the
  // edge that writes it and samples 1ns later.
  task automatic do_op(input logic [3:0] cmd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] pc, input logic br, input logic wb,
                       input bit scramble, output int sc);
    drv_dest = 5'($urandom);
    drv_reg2 = $urandom;
    drv_mr = 1'($urandom_range(0, 1));
    drv_mw = 1'($urandom_range(0, 1));
    EXE_CMD_in = cmd; Val1_in = v1; Val2_in = v2; PC_in = pc;
    Br_taken_in = br; WB_EN_in = wb; Dest_in = drv_dest; Reg2_in = drv_reg2;
    MEM_R_EN_in = drv_mr; MEM_W_EN_in = drv_mw;
    sc = 0;
    #1;
    while (stall === 1'b1 && sc < 100) begin
      sc++;
      @(posedge clk); #1;
      if (scramble) begin
        Val1_in = $urandom; Val2_in = $urandom; PC_in = $urandom;
        Dest_in = 5'($urandom); Reg2_in = $urandom;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_and_check(input string tag, input logic [3:0] cmd,
                                 input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] pc, input logic br, input logic wb,
                                 input bit scramble, input logic [31:0] exp_res);
    int sc;
    do_op(cmd, v1, v2, pc, br, wb, scramble, sc);
    check({tag, ".result"}, ALU_result, exp_res);
    check({tag, ".br_addr"}, Br_addr, model_br(pc, v2));
    check({tag, ".br_taken"}, 32'(Br_taken), 32'(br));
    check({tag, ".wb_en"}, 32'(WB_EN), 32'(wb));
    check({tag, ".mem_r_en"}, 32'(MEM_R_EN), 32'(drv_mr));
    check({tag, ".mem_w_en"}, 32'(MEM_W_EN), 32'(drv_mw));
    check({tag, ".dest"}, 32'(Dest), 32'(drv_dest));
    check({tag, ".st_val"}, ST_val, drv_reg2);
    check({tag, ".stall_cycles"}, 32'(sc), (cmd == 4'hC) ? 32'd33 : 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] pc;
    logic        br;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] prev;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{"add_wrap",  4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0,   1'b0, 32'h0000_0000};
    vecs[1]  = '{"sub",       4'h2, 32'h5,         32'h7,         32'h40,  1'b0, 32'hFFFF_FFFE};
    vecs[2]  = '{"and",       4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h44,  1'b0, 32'h00F0_00F0};
    vecs[3]  = '{"or",        4'h5, 32'h1234_0000, 32'h0000_5678, 32'h48,  1'b1, 32'h1234_5678};
    vecs[4]  = '{"nor",       4'h6, 32'h0,         32'h0,         32'h4C,  1'b0, 32'hFFFF_FFFF};
    vecs[5]  = '{"xor",       4'h7, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h50,  1'b0, 32'h5555_5555};
    vecs[6]  = '{"sll33",     4'h8, 32'h3,         32'd33,        32'h54,  1'b0, 32'h0000_0006};
    vecs[7]  = '{"srl",       4'h9, 32'h8000_0000, 32'd31,        32'h58,  1'b0, 32'h0000_0001};
    vecs[8]  = '{"sra",       4'hA, 32'h8000_0000, 32'd4,         32'h5C,  1'b0, 32'hF800_0000};
    vecs[9]  = '{"undef",     4'h3, 32'h1234_5678, 32'h1,         32'h60,  1'b0, 32'h0000_0000};
    vecs[10] = '{"branch",    4'h0, 32'h0,         32'h3,         32'h100, 1'b1, 32'h0000_0003};
    vecs[11] = '{"mul_16",    4'hC, 32'h0001_0000, 32'h0001_0001, 32'h64,  1'b0, 32'h0001_0000};

    // ---------------- reset ----------------
    rst = 1'b1; flush = 1'b0; PC_in = '0; Dest_in = '0; Reg2_in = '0;
    Val1_in = '0; Val2_in = '0; EXE_CMD_in = '0; Br_taken_in = 1'b0;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_EN_in = 1'b0;
    #3;
    check("reset.result", ALU_result, 32'h0);
    check("reset.wb_en", 32'(WB_EN), 32'h0);
    check("reset.br_addr", Br_addr, 32'h0);
    check("reset.stall", 32'(stall), 32'h0);
    check("reset.state", 32'(fsm_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // ---------------- fixed vectors ----------------
    for (int i = 0; i < 12; i++)
      apply_and_check(vecs[i].name, vecs[i].cmd, vecs[i].v1, vecs[i].v2,
                      vecs[i].pc, vecs[i].br, 1'b1, 1'b0, vecs[i].exp_res);
    check("branch.addr_const", model_br(32'h100, 32'h3), 32'h10C);

    // ---------------- flush mid-multiply ----------------
    prev = ALU_result;
    EXE_CMD_in = 4'hC; Val1_in = 32'd7; Val2_in = 32'd9; WB_EN_in = 1'b1;
    #1;
    check("flush.stall_start", 32'(stall), 32'h1);
    @(posedge clk); #1;
    check("flush.bubble_wb", 32'(WB_EN), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush.stall_drop", 32'(stall), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.wb_en", 32'(WB_EN), 32'h0);
    check("flush.result_held", ALU_result, prev);
    check("flush.state", 32'(fsm_state), 32'(ST_IDLE));
    apply_and_check("after_flush_add", 4'h0, 32'd2, 32'd3, 32'h200, 1'b0, 1'b1, 1'b0, 32'd5);

    // ---------------- reset mid-multiply ----------------
    EXE_CMD_in = 4'hC; Val1_in = 32'd6; Val2_in = 32'd7;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid.result", ALU_result, 32'h0);
    check("rst_mid.st_val", ST_val, 32'h0);
    check("rst_mid.stall", 32'(stall), 32'h0);
    check("rst_mid.state", 32'(fsm_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    apply_and_check("mul_3x5", 4'hC, 32'd3, 32'd5, 32'h300, 1'b1, 1'b1, 1'b0, 32'd15);
    apply_and_check("mul_b2b", 4'hC, 32'd11, 32'd13, 32'h304, 1'b0, 1'b1, 1'b0, 32'd143);

    // ---------------- random ----------------
    for (int i = 0; i < 24; i++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rc = 4'hC;
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      exp_q.push_back(model_alu(rc, ra, rb));
      apply_and_check($sformatf("rand%0d", i), rc, ra, rb, $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
